// File: rtl/square_wave_analyzer.sv
// ---------------------------------------------------------------------------
// square_wave_analyzer
//
// Recovers the sine-series coefficients of harmonics 1, 3, 5 and 7 and the DC
// mean of an 8-bit unsigned sample stream over one frame of 2^FRAME_LOG2
// accepted samples. The harmonic phases follow the PHASE_STEP phase-accumulator
// convention of the matching generator. Each harmonic has its own 4-stage
// pipeline: accept -> sine LUT read -> multiply -> accumulate.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   sample_in    unsigned sample, 128 = midscale
//   sample_valid qualifies sample_in (used only while accumulating)
//   start        one-cycle request to begin a frame (honoured in IDLE/DONE)
//   busy         high while a frame is accumulating or its pipeline drains
//   coef_valid   one-cycle pulse when the result outputs update
//   coef1..coef7 signed mean of x*sin(k*theta), x = sample - 128
//   dc_out       unsigned mean of the raw samples
// ---------------------------------------------------------------------------
module square_wave_analyzer #(
    parameter int PHASE_STEP = 256,
    parameter int FRAME_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sample_in,
    input  logic               sample_valid,
    input  logic               start,
    output logic               busy,
    output logic               coef_valid,
    output logic signed [15:0] coef1,
    output logic signed [15:0] coef3,
    output logic signed [15:0] coef5,
    output logic signed [15:0] coef7,
    output logic [7:0]         dc_out
);

    localparam int ACC_W = 17 + FRAME_LOG2;
    localparam int DC_W  = 8 + FRAME_LOG2;
    localparam int NH    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    // Quarter-wave table: round(127*sin(2*pi*i/256)) for i = 0..64.
    function automatic logic [6:0] quarter_sine(input logic [6:0] i);
        case (i)
            7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
            7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
            7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
            7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
            7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
            7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
            7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
            7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
            7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
            7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
            7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
            7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
            7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
            7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
            7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
            7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127;
            7'd64: return 7'd127;
            default: return 7'd0;
        endcase
    endfunction

    // Full 256-entry sine from the quarter table: the second quadrant mirrors
    // the first, the second half is the negated first half.
    function automatic logic signed [7:0] sine_lut(input logic [7:0] idx);
        logic [6:0] q_idx;
        logic [6:0] mag;
        q_idx = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        mag   = quarter_sine(q_idx);
        return idx[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    state_t                state_reg, state_next;
    logic [FRAME_LOG2-1:0] count_reg;
    logic [1:0]            drain_cnt_reg;

    logic accept;
    logic last_accept;
    logic frame_start;
    logic drain_last;

    assign accept      = (state_reg == S_ACCUM) && sample_valid;
    assign last_accept = accept && (count_reg == '1);
    assign frame_start = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    // Last DRAIN cycle: the final product has just reached the accumulators.
    assign drain_last  = (state_reg == S_DRAIN) && (drain_cnt_reg == 2'd3);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (last_accept) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_reg == 2'd3) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sample counter wraps to zero on the last accepted sample of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            drain_cnt_reg <= 2'd0;
        end else begin
            if (frame_start) begin
                count_reg <= '0;
            end else if (accept) begin
                count_reg <= count_reg + 1'b1;
            end
            if (state_reg == S_DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + 2'd1;
            end else begin
                drain_cnt_reg <= 2'd0;
            end
        end
    end

    // ---------------- shared sample pipeline ----------------
    logic signed [8:0]  x_in;
    logic               v0_reg, v1_reg, v2_reg;
    logic signed [8:0]  x0_reg, x1_reg;
    logic [7:0]         raw0_reg, raw1_reg, raw2_reg;
    logic signed [16:0] x1_ext;

    assign x_in   = $signed({1'b0, sample_in}) - 9'sd128;
    assign x1_ext = {{8{x1_reg[8]}}, x1_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_reg   <= 1'b0;
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            x0_reg   <= '0;
            x1_reg   <= '0;
            raw0_reg <= '0;
            raw1_reg <= '0;
            raw2_reg <= '0;
        end else begin
            v0_reg   <= accept;
            x0_reg   <= x_in;
            raw0_reg <= sample_in;
            v1_reg   <= v0_reg;
            x1_reg   <= x0_reg;
            raw1_reg <= raw0_reg;
            v2_reg   <= v1_reg;
            raw2_reg <= raw1_reg;
        end
    end

    // ---------------- per-harmonic phase, LUT, MAC ----------------
    logic [NH-1:0][15:0] coef_all;

    for (genvar gi = 0; gi < NH; gi++) begin : g_harm
        // Harmonic k = 2*gi+1 keeps its own accumulator advancing k*PHASE_STEP,
        // which equals k*theta mod 2^16 without a multiplier.
        localparam logic [15:0] HSTEP = 16'(((2 * gi) + 1) * PHASE_STEP);

        logic [15:0]             hphase_reg;
        logic [7:0]              idx_reg;
        logic signed [7:0]       lut_reg;
        logic signed [16:0]      lut_ext;
        logic signed [16:0]      prod_reg;
        logic signed [ACC_W-1:0] acc_reg;
        logic [15:0]             coef_reg;

        assign lut_ext = {{9{lut_reg[7]}}, lut_reg};

        always_ff @(posedge clk) begin
            if (rst) begin
                hphase_reg <= '0;
                idx_reg    <= '0;
                lut_reg    <= '0;
                prod_reg   <= '0;
                acc_reg    <= '0;
                coef_reg   <= '0;
            end else begin
                if (frame_start) begin
                    hphase_reg <= '0;
                end else if (accept) begin
                    hphase_reg <= hphase_reg + HSTEP;
                end
                idx_reg  <= hphase_reg[15:8];
                lut_reg  <= sine_lut(idx_reg);
                prod_reg <= x1_ext * lut_ext;
                if (frame_start) begin
                    acc_reg <= '0;
                end else if (v2_reg) begin
                    acc_reg <= acc_reg + {{FRAME_LOG2{prod_reg[16]}}, prod_reg};
                end
                // Arithmetic shift by FRAME_LOG2, truncated to 16 bits.
                if (drain_last) begin
                    coef_reg <= acc_reg[FRAME_LOG2 +: 16];
                end
            end
        end

        assign coef_all[gi] = coef_reg;
    end

    // ---------------- DC mean and result strobe ----------------
    logic [DC_W-1:0] dc_acc_reg;
    logic [7:0]      dc_out_reg;
    logic            coef_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc_reg     <= '0;
            dc_out_reg     <= '0;
            coef_valid_reg <= 1'b0;
        end else begin
            if (frame_start) begin
                dc_acc_reg <= '0;
            end else if (v2_reg) begin
                dc_acc_reg <= dc_acc_reg + {{FRAME_LOG2{1'b0}}, raw2_reg};
            end
            if (drain_last) begin
                dc_out_reg <= dc_acc_reg[FRAME_LOG2 +: 8];
            end
            coef_valid_reg <= drain_last;
        end
    end

    assign coef_valid = coef_valid_reg;
    assign dc_out     = dc_out_reg;
    assign coef1      = coef_all[0];
    assign coef3      = coef_all[1];
    assign coef5      = coef_all[2];
    assign coef7      = coef_all[3];

endmodule
